// File: rtl/cordic_rotator.sv
// -----------------------------------------------------------------------------
// cordic_rotator
//
// Fully pipelined CORDIC rotator (rotation mode). Rotates (Xin, Yin) by a
// signed 32-bit binary angle (2^32 = 360 degrees) and returns the K-scaled
// result (K ~= 1.6468) on Xout/Yout, WIDTH+2 clocks after the input is
// sampled. A new sample is accepted on every rising edge; there is no
// handshake and no stall.
//
// Pipeline: 1 quadrant pre-rotation stage, WIDTH micro-rotation stages,
// 1 saturating output stage.
//
// Ports:
//   clock     in   rising-edge clock
//   reset     in   asynchronous, active-high reset (clears every stage)
//   angle     in   [ANGLE_W-1:0] binary angle, 0x40000000 = 90 degrees
//   Xin, Yin  in   [WIDTH-1:0] signed input vector
//   Xout,Yout out  [WIDTH-1:0] signed rotated vector (registered, saturated)
//   in_valid  in   sample qualifier       (only with CORDIC_VALID_EN)
//   out_valid out  result qualifier       (only with CORDIC_VALID_EN)
//
// Build option:
//   CORDIC_VALID_EN - when defined, adds in_valid/out_valid and a WIDTH+2
//                     deep valid shift register aligned with the datapath.
// -----------------------------------------------------------------------------
module cordic_rotator #(
    parameter int WIDTH   = 16,
    parameter int ANGLE_W = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic       [ANGLE_W-1:0] angle,
    input  logic signed [WIDTH-1:0]  Xin,
    input  logic signed [WIDTH-1:0]  Yin,
`ifdef CORDIC_VALID_EN
    input  logic                     in_valid,
    output logic                     out_valid,
`endif
    output logic signed [WIDTH-1:0]  Xout,
    output logic signed [WIDTH-1:0]  Yout
);

    // Two guard bits: gain K < 2 and the pre-rotation negation of the most
    // negative input both fit, so no intermediate value can wrap.
    localparam int XW = WIDTH + 2;

    // atan(2^-i) scaled so that 2^32 is a full turn, rounded to nearest.
    function automatic logic [31:0] atan_lut(input int i);
        logic [31:0] r;
        r = '0;
        case (i)
            0:  r = 32'h2000_0000;
            1:  r = 32'h12E4_051E;
            2:  r = 32'h09FB_385B;
            3:  r = 32'h0511_11D4;
            4:  r = 32'h028B_0D43;
            5:  r = 32'h0145_D7E1;
            6:  r = 32'h00A2_F61E;
            7:  r = 32'h0051_7C55;
            8:  r = 32'h0028_BE53;
            9:  r = 32'h0014_5F2F;
            10: r = 32'h000A_2F98;
            11: r = 32'h0005_17CC;
            12: r = 32'h0002_8BE6;
            13: r = 32'h0001_45F3;
            14: r = 32'h0000_A2FA;
            15: r = 32'h0000_517D;
            16: r = 32'h0000_28BE;
            17: r = 32'h0000_145F;
            18: r = 32'h0000_0A30;
            19: r = 32'h0000_0518;
            20: r = 32'h0000_028C;
            21: r = 32'h0000_0146;
            22: r = 32'h0000_00A3;
            23: r = 32'h0000_0051;
            24: r = 32'h0000_0029;
            25: r = 32'h0000_0014;
            26: r = 32'h0000_000A;
            27: r = 32'h0000_0005;
            28: r = 32'h0000_0003;
            29: r = 32'h0000_0001;
            30: r = 32'h0000_0001;
            31: r = 32'h0000_0000;
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    // Clamp a guard-bit value into the signed WIDTH output range. In range
    // exactly when the top three bits agree.
    function automatic logic signed [WIDTH-1:0] saturate(input logic signed [XW-1:0] v);
        logic signed [WIDTH-1:0] r;
        // NOTE: r is given a value on every path before the branches, so the
        // logic stays purely combinational no matter which branch is taken.
        r = v[WIDTH-1:0];
        if (!(v[XW-1:WIDTH-1] == '0 || v[XW-1:WIDTH-1] == '1)) begin
            r = v[XW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
        return r;
    endfunction

    logic signed [XW-1:0]      xin_ext, yin_ext;
    logic signed [XW-1:0]      x [0:WIDTH];
    logic signed [XW-1:0]      y [0:WIDTH];
    logic        [ANGLE_W-1:0] z [0:WIDTH];

    assign xin_ext = {{2{Xin[WIDTH-1]}}, Xin};
    assign yin_ext = {{2{Yin[WIDTH-1]}}, Yin};

    // x/y/z[0] hold the pre-rotated sample; stage i maps index i to i+1.
    // z[WIDTH] is never consumed and is trimmed by synthesis.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            // NOTE: every pipeline stage is cleared, not just the outputs, so
            // in-flight samples are discarded and the outputs read 0 until a
            // post-reset sample has travelled the full pipe.
            for (int i = 0; i <= WIDTH; i++) begin
                x[i] <= '0;
                y[i] <= '0;
                z[i] <= '0;
            end
            Xout <= '0;
            Yout <= '0;
        end else begin
            // NOTE: all state uses non-blocking assignment, so each stage reads
            // the previous stage's value from before this edge.
            // Quadrant pre-rotation leaves a residual in [-90, +90) degrees,
            // inside the convergence range of the micro-rotations.
            case (angle[ANGLE_W-1 -: 2])
                2'b01: begin
                    x[0] <= -yin_ext;
                    y[0] <= xin_ext;
                    z[0] <= {2'b00, angle[ANGLE_W-3:0]};
                end
                2'b10: begin
                    x[0] <= yin_ext;
                    y[0] <= -xin_ext;
                    z[0] <= {2'b11, angle[ANGLE_W-3:0]};
                end
                default: begin
                    x[0] <= xin_ext;
                    y[0] <= yin_ext;
                    z[0] <= angle;
                end
            endcase

            // Micro-rotations: steer towards zero residual angle.
            for (int i = 0; i < WIDTH; i++) begin
                if (!z[i][ANGLE_W-1]) begin
                    x[i+1] <= x[i] - (y[i] >>> i);
                    y[i+1] <= y[i] + (x[i] >>> i);
                    z[i+1] <= z[i] - atan_lut(i);
                end else begin
                    x[i+1] <= x[i] + (y[i] >>> i);
                    y[i+1] <= y[i] - (x[i] >>> i);
                    z[i+1] <= z[i] + atan_lut(i);
                end
            end

            Xout <= saturate(x[WIDTH]);
            Yout <= saturate(y[WIDTH]);
        end
    end

`ifdef CORDIC_VALID_EN
    // One bit per register stage of the datapath, so the MSB lines up with
    // the sample currently on Xout/Yout.
    logic [WIDTH+1:0] vpipe;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vpipe <= '0;
        end else begin
            vpipe <= {vpipe[WIDTH:0], in_valid};
        end
    end

    assign out_valid = vpipe[WIDTH+1];
`endif

endmodule

// File: tb/tb_cordic_rotator.sv
// -----------------------------------------------------------------------------
// tb_cordic_rotator
//
// Self-checking bench for cordic_rotator. A floating-point model of the ideal
// K-scaled rotation (with output clamping) is compared against the DUT on
// every falling edge, using the inputs sampled WIDTH+2 rising edges earlier.
// Directed checks pin the model with hand-computed values (19429*K = 31995).
// -----------------------------------------------------------------------------
module tb_cordic_rotator;

    localparam int  W   = 16;
    localparam int  LAT = W + 2;
    localparam int  TOL = 8;
    localparam real PI  = 3.14159265358979323846;

    typedef struct packed {
        logic signed [W-1:0] xi;
        logic signed [W-1:0] yi;
        logic        [31:0]  a;
        logic                v;
    } sample_t;

    logic                clock = 1'b0;
    logic                reset = 1'b0;
    logic        [31:0]  angle = '0;
    logic signed [W-1:0] Xin   = '0;
    logic signed [W-1:0] Yin   = '0;
    logic                vin   = 1'b0;
    logic signed [W-1:0] Xout, Yout;
`ifdef CORDIC_VALID_EN
    logic                out_valid;
`endif

    int  checks   = 0;
    int  failures = 0;
    real kgain    = 1.0;

    sample_t hist [0:31];
    int      cnt = 0;

    cordic_rotator #(.WIDTH(W), .ANGLE_W(32)) dut (
        .clock    (clock),
        .reset    (reset),
        .angle    (angle),
        .Xin      (Xin),
        .Yin      (Yin),
`ifdef CORDIC_VALID_EN
        .in_valid (vin),
        .out_valid(out_valid),
`endif
        .Xout     (Xout),
        .Yout     (Yout)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp, input int tol);
        checks++;
        if (act < exp - tol || act > exp + tol) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d) at %0t", name, act, exp, tol, $time);
        end
    endtask

    // Ideal rotation of one sample, scaled by K and clamped to the output range.
    function automatic int ideal(input sample_t s, input bit want_y);
        real th, v;
        th = $itor($signed(s.a)) * 2.0 * PI / 4294967296.0;
        if (want_y) v = kgain * ($itor(s.xi) * $sin(th) + $itor(s.yi) * $cos(th));
        else        v = kgain * ($itor(s.xi) * $cos(th) - $itor(s.yi) * $sin(th));
        if (v > 32767.0)  v = 32767.0;
        if (v < -32768.0) v = -32768.0;
        return $rtoi(v >= 0.0 ? v + 0.5 : v - 0.5);
    endfunction

    // Input history: hist[k] is the sample taken on the (k+1)-th edge after reset.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= 0;
        end else begin
            hist[cnt % 32] <= {Xin, Yin, angle, vin};
            cnt            <= cnt + 1;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clock) begin : compare
        sample_t s;
        int      ex, ey, tol;
        logic    ev;
        if (reset || cnt < LAT) begin
            ex = 0; ey = 0; ev = 1'b0; tol = 0;
        end else begin
            s   = hist[(cnt - LAT) % 32];
            ex  = ideal(s, 1'b0);
            ey  = ideal(s, 1'b1);
            ev  = s.v;
            tol = TOL;
        end
        check("pipe_x", int'(Xout), ex, tol);
        check("pipe_y", int'(Yout), ey, tol);
`ifdef CORDIC_VALID_EN
        check("pipe_valid", int'(out_valid), int'(ev), 0);
`endif
    end

    task automatic drive(input int xi, input int yi, input logic [31:0] a);
        @(negedge clock);
        #1;
        Xin   = xi[W-1:0];
        Yin   = yi[W-1:0];
        angle = a;
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin : main
        logic [31:0] ang_tab [6];
        int          exx_tab [6];
        int          exy_tab [6];
        logic [63:0] t;

        for (int i = 0; i < W; i++) kgain = kgain * $sqrt(1.0 + 2.0 ** (-2.0 * i));

        // Asynchronous reset: outputs zero before any clock edge.
        #1 reset = 1'b1;
        #1;
        check("reset_x", int'(Xout), 0, 0);
        check("reset_y", int'(Yout), 0, 0);
        Xin = 16'sd19429;
        repeat (3) @(negedge clock);
        #1 reset = 1'b0;

        // Directed quadrant and wrap cases; 19429*K = 31995, *cos45 = 22624.
        ang_tab = '{32'h0000_0000, 32'h4000_0000, 32'h8000_0000,
                    32'hC000_0000, 32'h2000_0000, 32'hFFFF_FFFF};
        exx_tab = '{31995, 0, -31995, 0, 22624, 31995};
        exy_tab = '{0, 31995, 0, -31995, 22624, 0};
        for (int k = 0; k < 6; k++) begin
            drive(19429, 0, ang_tab[k]);
            hold(LAT + 2);
            check("dir_x", int'(Xout), exx_tab[k], TOL);
            check("dir_y", int'(Yout), exy_tab[k], TOL);
        end

        // Output saturation at both rails.
        drive(32767, 0, 32'h0);
        hold(LAT + 2);
        check("sat_pos", int'(Xout), 32767, 0);
        drive(-32768, 0, 32'h0);
        hold(LAT + 2);
        check("sat_neg", int'(Xout), -32768, 0);

        // Latency: step 0 -> 90 degrees together with a one-cycle valid pulse.
        drive(19429, 0, 32'h0);
        hold(LAT + 2);
        @(negedge clock);
        #1;
        angle = 32'h4000_0000;
        vin   = 1'b1;
        @(posedge clock);
        #1 vin = 1'b0;
        repeat (LAT - 2) @(posedge clock);
        #1;
        check("lat_before_x", int'(Xout), 31995, TOL);
        check("lat_before_y", int'(Yout), 0, TOL);
`ifdef CORDIC_VALID_EN
        check("lat_before_valid", int'(out_valid), 0, 0);
`endif
        @(posedge clock);
        #1;
        check("lat_after_x", int'(Xout), 0, TOL);
        check("lat_after_y", int'(Yout), 31995, TOL);
`ifdef CORDIC_VALID_EN
        check("lat_after_valid", int'(out_valid), 1, 0);
        @(posedge clock);
        #1 check("lat_pulse_end", int'(out_valid), 0, 0);
`endif

        // Degree sweep, with a reset asserted part way through.
        for (int i = 0; i <= 360; i++) begin
            t = (64'(i) << 32) / 64'd360;
            drive(19429, 0, t[31:0]);
            hold(19);
            if (i == 200) begin
                @(negedge clock);
                #2 reset = 1'b1;
                #1;
                check("async_rst_x", int'(Xout), 0, 0);
                check("async_rst_y", int'(Yout), 0, 0);
                angle = 32'h2000_0000;
                repeat (3) @(negedge clock);
                #1 reset = 1'b0;
                repeat (LAT - 1) @(posedge clock);
                #1;
                check("rst_lat_before_x", int'(Xout), 0, 0);
                @(posedge clock);
                #1;
                check("rst_lat_after_x", int'(Xout), 22624, TOL);
                check("rst_lat_after_y", int'(Yout), 22624, TOL);
            end
        end

        // Back-to-back random samples, one per clock.
        for (int n = 0; n < 600; n++) begin
            drive(int'($urandom_range(38858)) - 19429,
                  int'($urandom_range(38858)) - 19429,
                  $urandom());
            vin = 1'($urandom_range(1));
        end
        drive(0, 0, 32'h0);
        vin = 1'b0;
        hold(LAT + 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
